// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for a 6502-style CPU bus. It backs a DEPTH-byte
//   window at BASE with an on-chip byte array, overlays the six vector bytes
//   ($FFFA-$FFFF) with constants, and shares one write port between a
//   post-reset clear walk, CPU writes and a side-band loader.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   mem_data   (inout)  CPU data bus, driven only while serving a read
//   mem_read            1 = CPU read cycle, 0 = CPU write cycle
//   mem_addr_l/h        CPU address, low / high byte
//   ld_valid/addr/data  loader request (array index + byte)
//   ld_ready            loader request accepted this cycle
//   mem_ready           clear walk finished, CPU bus is being served
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int          ADDR_W  = 11,
  parameter logic [15:0] BASE    = 16'h0000,
  parameter logic [7:0]  FILL    = 8'h00,
  parameter logic [15:0] NMI_VEC = 16'h0000,
  parameter logic [15:0] RST_VEC = 16'h0000,
  parameter logic [15:0] IRQ_VEC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [7:0]        mem_data,
  input  logic              mem_read,
  input  logic [7:0]        mem_addr_l,
  input  logic [7:0]        mem_addr_h,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              mem_ready
);

  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [15:0] WIN_MASK = ~16'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_SERVE} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_nxt;

  logic [7:0]        r_mem [DEPTH];

  logic [15:0]       w_addr;
  logic              w_vec_hit, w_arr_hit;
  logic [ADDR_W-1:0] w_idx;
  logic [7:0]        w_vec_byte, w_rd_byte;
  logic              w_serve, w_cpu_wr, w_oe;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata;

  // ---------------------------------------------------------------- decode
  assign w_addr    = {mem_addr_h, mem_addr_l};
  assign w_vec_hit = (w_addr >= 16'hFFFA);
  // Vectors win even if the array window happens to cover the top page.
  assign w_arr_hit = ((w_addr & WIN_MASK) == BASE) && !w_vec_hit;
  assign w_idx     = w_addr[ADDR_W-1:0];

  // Little-endian vector overlay; $FFF8/$FFF9 never reach here (no vec_hit).
  always_comb begin
    w_vec_byte = 8'h00;
    case (w_addr[2:0])
      3'b010:  w_vec_byte = NMI_VEC[7:0];
      3'b011:  w_vec_byte = NMI_VEC[15:8];
      3'b100:  w_vec_byte = RST_VEC[7:0];
      3'b101:  w_vec_byte = RST_VEC[15:8];
      3'b110:  w_vec_byte = IRQ_VEC[7:0];
      3'b111:  w_vec_byte = IRQ_VEC[15:8];
      default: w_vec_byte = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_serve       = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
        if (r_clr_cnt == '1) w_next = S_SERVE;
      end
      S_SERVE: begin
        w_serve = 1'b1;
      end
      default: w_next = S_CLEAR;
    endcase
  end

  // mem_ready is the state register itself, so it rises the cycle after the
  // final clear write and drops the instant reset is asserted.
  assign mem_ready = w_serve;

  // ---------------------------------------------------------------- write port
  // CPU writes to the array outrank the loader; the loader sees that as a stall.
  assign w_cpu_wr = w_serve && !mem_read && w_arr_hit;
  assign ld_ready = w_serve && !(!mem_read && w_arr_hit);

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_cnt;
      w_wdata = FILL;
    end else if (w_cpu_wr) begin
      w_we    = 1'b1;
      w_waddr = w_idx;
      w_wdata = mem_data;
    end else if (ld_valid && ld_ready) begin
      w_we    = 1'b1;
      w_waddr = ld_addr;
      w_wdata = ld_data;
    end
  end

  // No reset on the array: the clear walk is what initialises it.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // ---------------------------------------------------------------- read port
  // Asynchronous read: a same-cycle write becomes visible from the next cycle.
  assign w_rd_byte = w_arr_hit ? r_mem[w_idx] : w_vec_byte;
  assign w_oe      = w_serve && mem_read && (w_arr_hit || w_vec_hit);
  assign mem_data  = w_oe ? w_rd_byte : 8'hzz;

endmodule
